// File: rtl/tile_map_line_fetcher_pkg.sv
// Shared constants, FSM state type and row-base helper for the tile map line fetcher.
package tile_map_pkg;
   localparam int MAP_COLS   = 40;
   localparam int MAP_ROWS   = 30;
   localparam int TILE_SHIFT = 4;
   localparam int MAP_DEPTH  = 1200;
   localparam int ADDR_W     = 11;
   localparam int DATA_W     = 8;
   localparam int COL_W      = 6;
   localparam int ROW_W      = 5;
   localparam int LINE_W     = 10;

   // First pixel row below the map; line_y at or beyond this has no tile row.
   localparam logic [LINE_W-1:0] LINE_LIMIT = LINE_W'(MAP_ROWS << TILE_SHIFT);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, SWAP} fetch_state_t;

   typedef logic [DATA_W-1:0] tile_id_t;

   // row*40 as shift-and-add; fits 11 bits for every row up to 29.
   function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] row);
      return (ADDR_W'(row) << 5) + (ADDR_W'(row) << 3);
   endfunction
endpackage

// File: rtl/tile_map_line_fetcher_if.sv
// Map RAM read-port bus between the line fetcher (master) and the tile map RAM (slave).
interface tile_map_line_fetcher_if;
   import tile_map_pkg::*;

   logic [ADDR_W-1:0] map_address;
   logic              map_chipselect;
   logic              map_clken;
   logic              map_write;
   tile_id_t          map_readdata;

   modport master (
      output map_address, map_chipselect, map_clken, map_write,
      input  map_readdata
   );

   modport slave (
      input  map_address, map_chipselect, map_clken, map_write,
      output map_readdata
   );
endinterface

// File: rtl/tile_map_line_fetcher_buffer.sv
// Ping-pong tile line buffer: writes land in the back bank, registered reads come from the front bank.
module tile_line_buffer
   import tile_map_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [COL_W-1:0] wr_col,
   input  tile_id_t         wr_data,
   input  logic             swap,
   input  logic [COL_W-1:0] rd_col,
   output tile_id_t         rd_data
);
   logic             sel_reg;
   logic             rd_valid_reg;
   logic             rd_bank_reg;
   logic [COL_W-1:0] rd_idx;

   assign rd_idx = (rd_col < COL_W'(MAP_COLS)) ? rd_col : '0;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         tile_id_t mem [MAP_COLS];
         tile_id_t q_reg;

         always_ff @(posedge clk) begin
            if (wr_en && (sel_reg != 1'(gi)))
               mem[wr_col] <= wr_data;
            q_reg <= mem[rd_idx];
         end
      end
   endgenerate

   // Bank choice is captured with the read so a read in the swap cycle still sees the old front.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_reg      <= 1'b0;
         rd_valid_reg <= 1'b0;
         rd_bank_reg  <= 1'b0;
      end else begin
         if (swap)
            sel_reg <= ~sel_reg;
         rd_valid_reg <= (rd_col < COL_W'(MAP_COLS));
         rd_bank_reg  <= sel_reg;
      end
   end

   assign rd_data = !rd_valid_reg ? '0 :
                    (rd_bank_reg ? g_bank[1].q_reg : g_bank[0].q_reg);
endmodule

// File: rtl/tile_map_line_fetcher.sv
// Fetches the 40 tile indices of the next scanline's tile row into a ping-pong line buffer.
// Optional TILE_MAP_ROW_CACHE_EN skips the fetch when the requested row is already in front.
module tile_map_line_fetcher
   import tile_map_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     line_start,
   input  logic [LINE_W-1:0]        line_y,
   tile_map_line_fetcher_if.master  map,
   input  logic [COL_W-1:0]         rd_col,
   output tile_id_t                 tile_id,
   output logic                     busy,
   output logic                     overrun
);
   fetch_state_t      state_reg, state_next;
   logic [COL_W-1:0]  col_reg, col_next;
   logic [ADDR_W-1:0] base_reg, base_next;
   logic              overrun_reg, overrun_next;
   logic [ROW_W-1:0]  row_y;
   logic              line_valid;
   logic              start_ok;
   logic              wr_en;
`ifdef TILE_MAP_ROW_CACHE_EN
   logic [ROW_W-1:0]  row_reg, row_next;
   logic [ROW_W-1:0]  cached_row_reg;
`endif

   assign row_y      = ROW_W'(line_y >> TILE_SHIFT);
   assign line_valid = (line_y < LINE_LIMIT);
`ifdef TILE_MAP_ROW_CACHE_EN
   assign start_ok   = line_valid && (row_y != cached_row_reg);
`else
   assign start_ok   = line_valid;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         col_reg        <= '0;
         base_reg       <= '0;
         overrun_reg    <= 1'b0;
`ifdef TILE_MAP_ROW_CACHE_EN
         row_reg        <= '1;
         cached_row_reg <= '1;
`endif
      end else begin
         state_reg   <= state_next;
         col_reg     <= col_next;
         base_reg    <= base_next;
         overrun_reg <= overrun_next;
`ifdef TILE_MAP_ROW_CACHE_EN
         row_reg     <= row_next;
         if (state_reg == SWAP)
            cached_row_reg <= row_reg;
`endif
      end
   end

   always_comb begin
      state_next   = state_reg;
      col_next     = col_reg;
      base_next    = base_reg;
      overrun_next = overrun_reg;
      wr_en        = 1'b0;
`ifdef TILE_MAP_ROW_CACHE_EN
      row_next     = row_reg;
`endif
      case (state_reg)
         IDLE: ;
         FETCH: begin
            // Data for the previous cycle's address arrives now; column 0 has nothing yet.
            wr_en    = (col_reg != '0);
            col_next = col_reg + COL_W'(1);
            if (col_reg == COL_W'(MAP_COLS - 1))
               state_next = DRAIN;
         end
         DRAIN: begin
            wr_en      = 1'b1;
            state_next = SWAP;
         end
         SWAP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      if (line_start) begin
         if (state_reg == FETCH || state_reg == DRAIN) begin
            overrun_next = 1'b1;
            state_next   = IDLE;
            wr_en        = 1'b0;
         end
         if (state_next == IDLE && start_ok) begin
            state_next = FETCH;
            col_next   = '0;
            base_next  = row_base(row_y);
`ifdef TILE_MAP_ROW_CACHE_EN
            row_next   = row_y;
`endif
         end
      end
   end

   assign map.map_address    = base_reg + ADDR_W'(col_reg);
   assign map.map_chipselect = (state_reg == FETCH);
   assign map.map_clken      = (state_reg != IDLE);
   assign map.map_write      = 1'b0;
   assign busy               = (state_reg != IDLE);
   assign overrun            = overrun_reg;

   tile_line_buffer u_buffer (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en),
      .wr_col  (col_reg - COL_W'(1)),
      .wr_data (map.map_readdata),
      .swap    (state_reg == SWAP),
      .rd_col  (rd_col),
      .rd_data (tile_id)
   );
endmodule

// File: tb/tb_tile_map_line_fetcher.sv
// Self-checking bench for tile_map_line_fetcher: directed scenarios, then random lines vs a row-level model.
module tb_tile_map_line_fetcher;
   import tile_map_pkg::*;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             line_start = 1'b0;
   logic [LINE_W-1:0] line_y = '0;
   logic [COL_W-1:0] rd_col = '0;
   tile_id_t         tile_id;
   logic             busy;
   logic             overrun;

   tile_map_line_fetcher_if bus();

   tile_map_line_fetcher dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .line_start (line_start),
      .line_y     (line_y),
      .map        (bus),
      .rd_col     (rd_col),
      .tile_id    (tile_id),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   logic [7:0] ram [0:MAP_DEPTH-1];
   always @(posedge clk)
      if (bus.map_chipselect && bus.map_clken)
         bus.map_readdata <= ram[bus.map_address];

   // Model: what the pixel stage should see, tracked per completed row fetch.
   logic [7:0] front_m [MAP_COLS];
   int         last_row = -1;

   int busy_cycles = 0;
   int addr_q[$];
   always @(posedge clk) begin
      #1;
      if (busy) busy_cycles++;
      if (bus.map_chipselect) addr_q.push_back(int'(bus.map_address));
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit model_fetches(input int y);
      int row = y / 16;
      if (y >= MAP_ROWS * 16) return 1'b0;
`ifdef TILE_MAP_ROW_CACHE_EN
      if (row == last_row) return 1'b0;
`endif
      return 1'b1;
   endfunction

   task automatic model_load(input int row);
      for (int c = 0; c < MAP_COLS; c++) front_m[c] = ram[row * MAP_COLS + c];
      last_row = row;
   endtask

   task automatic pulse_line(input int y);
      @(negedge clk);
      line_y = LINE_W'(y);
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_timeout"}, int'(busy), 0);
   endtask

   task automatic run_line(input int y, input string tag);
      bit fetch;
      int bad;
      fetch = model_fetches(y);
      busy_cycles = 0;
      addr_q.delete();
      pulse_line(y);
      wait_idle(tag);
      repeat (2) @(negedge clk);
      chk({tag, "_reads"}, addr_q.size(), fetch ? MAP_COLS : 0);
      chk({tag, "_busy"}, busy_cycles, fetch ? 42 : 0);
      if (fetch) begin
         bad = 0;
         for (int i = 0; i < addr_q.size(); i++)
            if (addr_q[i] != (y / 16) * MAP_COLS + i) bad++;
         chk({tag, "_addr"}, bad, 0);
         model_load(y / 16);
      end
   endtask

   task automatic read_col(input int c, input string tag);
      @(negedge clk);
      rd_col = COL_W'(c);
      @(negedge clk);
      chk(tag, int'(tile_id), (c < MAP_COLS) ? int'(front_m[c]) : 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int y;
      for (int k = 0; k < MAP_DEPTH; k++) ram[k] = 8'(k % 256);

      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_cs", int'(bus.map_chipselect), 0);
      chk("rst_clken", int'(bus.map_clken), 0);
      chk("rst_write", int'(bus.map_write), 0);
      chk("rst_tile_id", int'(tile_id), 0);
      reset_n = 1'b1;

      run_line(0, "y0");
      read_col(5, "y0_col5");
      chk("y0_col5_abs", int'(tile_id), 5);

      run_line(479, "y479");
      read_col(39, "y479_col39");
      chk("y479_col39_abs", int'(tile_id), 175);

      read_col(7, "pre_invalid");
      run_line(480, "y480");
      chk("y480_tile_id", int'(tile_id), int'(front_m[7]));
      run_line(1023, "y1023");
      chk("y1023_tile_id", int'(tile_id), 143);
      chk("no_overrun_yet", int'(overrun), 0);

      // Overrun: second request lands 10 cycles into the first fetch.
      pulse_line(32);
      repeat (8) @(negedge clk);
      @(negedge clk);
      line_y = 10'd48;
      line_start = 1'b1;
      addr_q.delete();
      busy_cycles = 0;
      @(negedge clk);
      line_start = 1'b0;
      wait_idle("ovr");
      repeat (2) @(negedge clk);
      chk("ovr_flag", int'(overrun), 1);
      chk("ovr_reads", addr_q.size(), 40);
      chk("ovr_first_addr", (addr_q.size() > 0) ? addr_q[0] : -1, 120);
      chk("ovr_busy", busy_cycles, 42);
      model_load(3);
      read_col(0, "ovr_col0");
      read_col(39, "ovr_col39");

      // Asynchronous reset in the middle of a fetch.
      pulse_line(64);
      repeat (19) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_busy", int'(busy), 0);
      chk("arst_overrun", int'(overrun), 0);
      chk("arst_cs", int'(bus.map_chipselect), 0);
      chk("arst_clken", int'(bus.map_clken), 0);
      @(negedge clk);
      reset_n = 1'b1;
      busy_cycles = 0;
      addr_q.delete();
      last_row = -1;
      repeat (30) @(negedge clk);
      chk("arst_no_reads", addr_q.size(), 0);
      chk("arst_no_busy", busy_cycles, 0);
      run_line(100, "post_rst");
      read_col(3, "post_rst_col3");

      // Same tile row twice: only the cached build skips the second fetch.
      run_line(16, "y16");
      run_line(17, "y17");
      read_col(17, "y17_col17");

      for (int k = 0; k < MAP_DEPTH; k++) ram[k] = 8'($urandom);
      for (int it = 0; it < 10; it++) begin
         y = int'($urandom_range(0, 560));
         run_line(y, $sformatf("rnd%0d_y%0d", it, y));
         for (int r = 0; r < 3; r++)
            read_col(int'($urandom_range(0, 45)), $sformatf("rnd%0d_rd%0d", it, r));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tile_map_line_fetcher.md
Name: tile_map_line_fetcher

Overview:
- Downstream consumer of the 1200-entry tile map RAM (40x30 tiles, 8-bit tile index per entry).
- On each scanline-start pulse, bursts the 40 tile indices of the tile row covering the next scanline into a back line buffer, then swaps it to the front buffer.
- The pixel stage reads the front buffer by tile column with 1-cycle latency.
- Sits between the map RAM read port and the tile pixel/palette stage.

Parameters:
- MAP_COLS, 40, tiles per map row.
- MAP_ROWS, 30, tile rows in the map.
- TILE_SHIFT, 4, log2 of tile height in pixels (16-pixel tiles).
- ADDR_W, 11, map RAM address width.
- DATA_W, 8, tile index width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- line_start  in  1  one-cycle pulse requesting a fetch for line_y.
- line_y  in  10  pixel row of the upcoming scanline; sampled when line_start=1.
- map_address  out  11  map RAM address.
- map_chipselect  out  1  map RAM select; high only while reads are issued.
- map_clken  out  1  map RAM clock enable; tied high while busy, otherwise low.
- map_write  out  1  constant 0; this block never writes the map.
- map_readdata  in  8  map RAM data, valid 1 cycle after the address is presented.
- rd_col  in  6  tile column requested by the pixel stage (0..39).
- tile_id  out  8  front-buffer entry for the previous cycle's rd_col.
- busy  out  1  fetch in progress.
- overrun  out  1  sticky flag: a line_start arrived while busy. Cleared only by reset.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, both buffers undefined, front-buffer select = 0, cached row = all-ones (invalid).
- line_start in IDLE, line_y < MAP_ROWS<<TILE_SHIFT:
  - row = line_y >> TILE_SHIFT.
  - base = row*40, computed as (row<<5)+(row<<3), 11-bit, no overflow for row <= 29.
  - Go to FETCH.
- line_start in IDLE, line_y >= 480: ignored. No fetch, no swap.
- FETCH: issues addresses base+0 .. base+39, one per cycle, with map_chipselect=1 and issue counter col_i 0..39.
  - Data captured with 1-cycle latency into back[col_i-1].
  - After address base+39, go to DRAIN for 1 cycle to capture the last word.
- DRAIN → SWAP: toggle front/back select, record cached row, go to IDLE.
- Fetch duration: line_start at cycle T → busy high T+1..T+42. Swap is visible to tile_id reads issued from cycle T+43.
- tile_id is registered: tile_id(t+1) = front[rd_col(t)].
  - rd_col >= 40 returns 0.
  - A read in the swap cycle returns the old front buffer.
- line_start while busy (FETCH or DRAIN):
  - Abort the fetch; no swap, front buffer unchanged.
  - Set overrun.
  - Restart the fetch with the new line_y on the next cycle (IDLE semantics applied immediately).
- reset_n deasserted mid-fetch: immediate return to reset values. The front buffer may hold stale data; the pixel stage ignores it until the first completed swap.

Optional Feature:
- Macro: TILE_MAP_ROW_CACHE_EN.
- Defined: if the computed row equals the cached row at line_start, no fetch and no swap occur; busy stays low and the front buffer is reused (15 of every 16 lines skip the RAM).
- Not defined: every valid line_start performs the full 42-cycle fetch and swap.

Decomposition:
- Shared package tile_map_pkg:
  - constants MAP_COLS, MAP_ROWS, TILE_SHIFT, MAP_DEPTH=1200.
  - FSM state typedef {IDLE, FETCH, DRAIN, SWAP}.
  - tile_id_t (8-bit).
- One natural sub-module, tile_line_buffer: 2x40x8 ping-pong storage with write port, registered read port and a select toggle.
- Address generation and the FSM stay in the top module.

Test Plan:
- Map entry k preloaded with k mod 256; line_start with line_y=0 → addresses 0..39 issued consecutively, busy high 42 cycles; afterwards rd_col=5 → tile_id=5 one cycle later.
- line_y=479 → base=1160; after swap, rd_col=39 → tile_id=1199 mod 256 = 175.
- line_y=480 and line_y=1023 → no map_chipselect activity, busy stays 0, tile_id unchanged.
- line_start(line_y=32) at T, then line_start(line_y=48) at T+10 → overrun=1; fetch restarts at base 120; final rd_col=0 → tile_id=120; no swap occurs for row 2.
- reset_n pulsed low at fetch cycle 20 → busy=0, overrun=0 and map_chipselect=0 immediately (asynchronously), with no swap afterwards.
- With TILE_MAP_ROW_CACHE_EN: line_y=16 then line_y=17 → second line_start produces no RAM reads. Without the macro, the second line_start produces 40 reads.
